// File: rtl/seg7_pkg.sv
// seg7_pkg: register map, CTRL field positions and hex segment table for seg7_display_bank
package seg7_pkg;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_PERIOD = 4'd9;
  localparam logic [3:0] ADDR_STATUS = 4'd10;
  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_DECODE_LSB = 8;
  localparam int CTRL_BLINK_LSB  = 16;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg7_display_bank_if.sv
// seg7_display_bank_if: Avalon-MM slave port of the display bank
interface seg7_display_bank_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: 4-bit value to active-high gfedcba segment pattern
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[val];
endmodule

// File: rtl/seg7_display_bank.sv
// seg7_display_bank: register-mapped seven-segment bank with hex decode, enable and blink
module seg7_display_bank
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_W    = 24,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  seg7_display_bank_if.slave      bus,
  output logic [7*NUM_DIGITS-1:0] seg_out
);
  localparam logic [6:0] SEG_POL = ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
  localparam logic [7*NUM_DIGITS-1:0] SEG_OFF = ACTIVE_LOW != 0 ? '1 : '0;
  logic [6:0] digit_q [NUM_DIGITS];
  logic [6:0] digit_d [NUM_DIGITS];
  logic [6:0] hex [NUM_DIGITS];
  logic en_q, en_d, phase_q, phase_d;
  logic [NUM_DIGITS-1:0] dec_q, dec_d, blk_q, blk_d;
  logic [BLINK_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [31:0] rdata;
  logic wr;
  assign wr = bus.chipselect && !bus.write_n;
  genvar g;
  for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_hex_decoder u_dec (.val(digit_q[g][3:0]), .seg(hex[g]));
  end
  always_comb begin
    digit_d  = digit_q;
    en_d     = en_q;
    dec_d    = dec_q;
    blk_d    = blk_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    seg_d    = seg_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (wr && bus.address == 4'(i)) digit_d[i] = bus.writedata[6:0];
    if (wr && bus.address == ADDR_CTRL) begin
      en_d  = bus.writedata[CTRL_ENABLE];
      dec_d = bus.writedata[CTRL_DECODE_LSB +: NUM_DIGITS];
      blk_d = bus.writedata[CTRL_BLINK_LSB +: NUM_DIGITS];
    end
    // a PERIOD write restarts the prescaler and wins over a same-cycle reload
    if (wr && bus.address == ADDR_PERIOD) begin
      period_d = bus.writedata[BLINK_W-1:0];
      cnt_d    = bus.writedata[BLINK_W-1:0];
      phase_d  = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = period_q;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    for (int i = 0; i < NUM_DIGITS; i++)
      seg_d[7*i +: 7] = SEG_POL ^ ((!en_q || (blk_q[i] && !phase_q)) ? 7'h00 :
                                   (dec_q[i] ? hex[i] : digit_q[i]));
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bus.address == 4'(i)) rdata = 32'(digit_q[i]);
    if (bus.address == ADDR_CTRL) begin
      rdata[CTRL_ENABLE] = en_q;
      rdata[CTRL_DECODE_LSB +: NUM_DIGITS] = dec_q;
      rdata[CTRL_BLINK_LSB +: NUM_DIGITS] = blk_q;
    end
    if (bus.address == ADDR_PERIOD) rdata = 32'(period_q);
    if (bus.address == ADDR_STATUS) rdata = 32'(phase_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      en_q     <= 1'b1;
      dec_q    <= '0;
      blk_q    <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      seg_q    <= SEG_OFF;
    end else begin
      digit_q  <= digit_d;
      en_q     <= en_d;
      dec_q    <= dec_d;
      blk_q    <= blk_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
    end
  end
  assign bus.readdata = rdata;
  assign seg_out = seg_q;
endmodule

// File: tb/tb_seg7_display_bank.sv
// tb_seg7_display_bank: directed checks of registers, decode, blink timing and reset
module tb_seg7_display_bank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [41:0] seg_out;
  int checks = 0;
  int errors = 0;
  localparam logic [41:0] ALL_OFF = '1;
  seg7_display_bank_if bus ();
  seg7_display_bank #(.NUM_DIGITS(6), .BLINK_W(24), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .seg_out(seg_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(tag, 64'(bus.readdata), 64'(exp));
  endtask
  initial begin
    bus.address = '0;
    bus.writedata = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_seg", 64'(seg_out), 64'(ALL_OFF));
    rd_chk("reset_ctrl", 4'd8, 32'h1);
    rd_chk("reset_status", 4'd10, 32'h1);
    rd_chk("reset_period", 4'd9, 32'h0);
    wr(4'd8, 32'h0000_0601);
    wr(4'd1, 32'h0000_007B);
    wr(4'd2, 32'h0000_0005);
    @(negedge clk);
    chk("dec_digit2", 64'(seg_out[20:14]), 64'h12);
    chk("dec_digit1_hi_ignored", 64'(seg_out[13:7]), 64'h03);
    rd_chk("ctrl_readback", 4'd8, 32'h0000_0601);
    rd_chk("digit1_readback", 4'd1, 32'h7B);
    wr(4'd8, 32'hFFFF_FFFF);
    rd_chk("ctrl_mask_trunc", 4'd8, 32'h003F_3F01);
    wr(4'd8, 32'h0000_0001);
    @(negedge clk);
    chk("raw_digit2", 64'(seg_out[20:14]), 64'h7A);
    chk("raw_digit1", 64'(seg_out[13:7]), 64'h04);
    wr(4'd7, 32'h0000_007F);
    @(negedge clk);
    chk("digit7_ignored", 64'(seg_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7A, 7'h04, 7'h7F}));
    rd_chk("read_addr7", 4'd7, 32'h0);
    rd_chk("read_addr6", 4'd6, 32'h0);
    rd_chk("read_addr12", 4'd12, 32'h0);
    wr(4'd0, 32'h0000_007F);
    wr(4'd8, 32'h0001_0001);
    wr(4'd9, 32'h0000_0003);
    rd_chk("period_readback", 4'd9, 32'h3);
    for (int k = 0; k < 17; k++) begin
      if (k > 0) @(negedge clk);
      bus.address = 4'd10;
      #1;
      chk($sformatf("blink_d0_k%0d", k), 64'(seg_out[6:0]),
          ((k >= 5 && k <= 8) || k >= 13) ? 64'h7F : 64'h00);
      chk($sformatf("steady_d1_k%0d", k), 64'(seg_out[13:7]), 64'h04);
      chk($sformatf("phase_k%0d", k), 64'(bus.readdata),
          ((k >= 4 && k <= 7) || (k >= 12 && k <= 15)) ? 64'h0 : 64'h1);
    end
    repeat (3) @(negedge clk);
    rd_chk("phase_before_cnt0_write", 4'd10, 32'h1);
    wr(4'd9, 32'h0000_0002);
    rd_chk("cnt0_write_no_toggle", 4'd10, 32'h1);
    @(negedge clk);
    rd_chk("phase_p1", 4'd10, 32'h1);
    @(negedge clk);
    rd_chk("phase_p2", 4'd10, 32'h1);
    @(negedge clk);
    rd_chk("phase_toggle_p3", 4'd10, 32'h0);
    wr(4'd8, 32'h0000_0000);
    @(negedge clk);
    chk("disable_all_dark", 64'(seg_out), 64'(ALL_OFF));
    rd_chk("ctrl_disabled", 4'd8, 32'h0);
    wr(4'd8, 32'h0001_0001);
    @(negedge clk);
    chk("reenabled_d1", 64'(seg_out[13:7]), 64'h04);
    reset = 1'b1;
    bus.address = 4'd3;
    bus.writedata = 32'h7F;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    chk("midreset_seg", 64'(seg_out), 64'(ALL_OFF));
    rd_chk("midreset_ctrl", 4'd8, 32'h1);
    rd_chk("midreset_status", 4'd10, 32'h1);
    rd_chk("midreset_period", 4'd9, 32'h0);
    rd_chk("midreset_digit3_write_lost", 4'd3, 32'h0);
    rd_chk("midreset_digit1", 4'd1, 32'h0);
    @(negedge clk);
    chk("post_reset_seg", 64'(seg_out), 64'(ALL_OFF));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
